fft_frame_feeder: RTL and testbench

Collects one frame of real ADC samples into an internal frame buffer and streams it into the FFT core's AXI4-Stream data input. Honours the FFT's `tready` back-pressure and issues the per-frame configuration beat ahead of the data. It is the transmitting end of the FFT input interface, sitting between the oscilloscope ADC capture path and the FFT IP instance.

---
 rtl/fft_frame_feeder_if.sv | 22 ++
 rtl/fft_frame_feeder.sv | 180 ++++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_feeder_if.sv
// AXI4-Stream link from the frame feeder into the FFT core: one config channel
// (direction bit) and one data channel carrying {im, re} with tlast.
interface fft_frame_feeder_if #(
  parameter int INPUT_WIDTH = 16
);
  logic                       cfg_tvalid;
  logic                       cfg_tdata;
  logic                       data_tvalid;
  logic [2*INPUT_WIDTH-1:0]   data_tdata;
  logic                       data_tlast;
  logic                       data_tready;

  modport master (
    output cfg_tvalid, cfg_tdata, data_tvalid, data_tdata, data_tlast,
    input  data_tready
  );

  modport slave (
    input  cfg_tvalid, cfg_tdata, data_tvalid, data_tdata, data_tlast,
    output data_tready
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Captures one frame of offset-binary ADC samples into a buffer, then emits a
// config beat followed by the frame as an AXI4-Stream burst into the FFT.
module fft_frame_feeder #(
  parameter int LOGS_FFT_LEN = 10,
  parameter int SAMPLE_WIDTH = 8,
  parameter int INPUT_WIDTH  = 16
) (
  input  logic                    i_aclk,
  input  logic                    i_rst,
  input  logic                    i_arm,
  input  logic                    i_continuous,
  input  logic                    i_fft_dir,
  input  logic                    i_smp_vld,
  input  logic [SAMPLE_WIDTH-1:0] i_smp,
  fft_frame_feeder_if.master      axis,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_overrun
);
  localparam int N     = 1 << LOGS_FFT_LEN;
  localparam int PTR_W = LOGS_FFT_LEN + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);
  localparam logic [PTR_W-1:0] END_IDX  = PTR_W'(N);

  typedef enum logic [1:0] {IDLE, FILL, CFG, SEND} state_t;

  state_t                        state;
  logic [PTR_W-1:0]              wr_ptr;
  logic [PTR_W-1:0]              rd_ptr;
  logic signed [INPUT_WIDTH-1:0] mem [N];

  logic signed [INPUT_WIDTH-1:0] re_p1;
  logic                          vld_p1;
  logic                          last_p1;
  logic signed [INPUT_WIDTH-1:0] skid_re [2];
  logic [1:0]                    skid_last;
  logic [1:0]                    skid_cnt;
  logic signed [INPUT_WIDTH-1:0] re_p2;
  logic                          vld_p2;
  logic                          last_p2;

  logic                          cfg_vld;
  logic                          cfg_dir;
  logic                          frame_done;
  logic                          overrun;

  logic                          wr_en;
  logic                          rd_en;
  logic                          hs;
  logic                          load_out;
  logic [2:0]                    occ_next;

  function automatic logic signed [INPUT_WIDTH-1:0] to_twos(input logic [SAMPLE_WIDTH-1:0] s);
    logic signed [SAMPLE_WIDTH-1:0] t;
    t = {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2:0]};
    return INPUT_WIDTH'(t);
  endfunction

  // A read is issued only if the skid buffer can absorb it once it lands,
  // counting the read already in flight and any entry leaving this cycle.
  always_comb begin
    wr_en    = (state == FILL) && i_smp_vld;
    hs       = vld_p2 && axis.data_tready;
    load_out = (skid_cnt != 2'd0) && (!vld_p2 || hs);
    occ_next = 3'(skid_cnt) + 3'(vld_p1) - 3'(load_out);
    rd_en    = (state == SEND) && (rd_ptr < END_IDX) && (occ_next < 3'd2);
  end

  // p0 -> p1: single-port frame buffer with registered read
  always_ff @(posedge i_aclk) begin
    if (wr_en)
      mem[wr_ptr[LOGS_FFT_LEN-1:0]] <= to_twos(i_smp);
    else if (rd_en)
      re_p1 <= mem[rd_ptr[LOGS_FFT_LEN-1:0]];
  end

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      skid_re[0] <= '0;
      skid_re[1] <= '0;
      skid_last  <= '0;
      skid_cnt   <= '0;
      re_p2      <= '0;
      vld_p2     <= 1'b0;
      last_p2    <= 1'b0;
      cfg_vld    <= 1'b0;
      cfg_dir    <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cfg_vld    <= 1'b0;
      cfg_dir    <= 1'b0;
      frame_done <= 1'b0;

      vld_p1  <= rd_en;
      last_p1 <= rd_en && (rd_ptr == LAST_IDX);
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;

      // p1 -> skid: entry 0 is always the head
      case ({vld_p1, load_out})
        2'b10: begin
          skid_re[skid_cnt[0]]   <= re_p1;
          skid_last[skid_cnt[0]] <= last_p1;
          skid_cnt               <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid_re[0]   <= skid_re[1];
          skid_last[0] <= skid_last[1];
          skid_cnt     <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid_re[0]   <= re_p1;
            skid_last[0] <= last_p1;
          end else begin
            skid_re[0]   <= skid_re[1];
            skid_last[0] <= skid_last[1];
            skid_re[1]   <= re_p1;
            skid_last[1] <= last_p1;
          end
        end
        default: ;
      endcase

      // skid -> p2: output register, held while the FFT stalls
      if (load_out) begin
        vld_p2  <= 1'b1;
        re_p2   <= skid_re[0];
        last_p2 <= skid_last[0];
      end else if (hs) begin
        vld_p2  <= 1'b0;
        last_p2 <= 1'b0;
      end

      case (state)
        IDLE: if (i_arm) begin
          state   <= FILL;
          wr_ptr  <= '0;
          overrun <= 1'b0;
        end
        FILL: if (i_smp_vld) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LAST_IDX) begin
            state   <= CFG;
            cfg_vld <= 1'b1;
            cfg_dir <= i_fft_dir;
          end
        end
        CFG: begin
          state  <= SEND;
          rd_ptr <= '0;
        end
        SEND: if (hs && last_p2) begin
          frame_done <= 1'b1;
          wr_ptr     <= '0;
          state      <= i_continuous ? FILL : IDLE;
        end
        default: state <= IDLE;
      endcase

      if (i_smp_vld && (state == CFG || state == SEND))
        overrun <= 1'b1;
    end
  end

  assign axis.cfg_tvalid  = cfg_vld;
  assign axis.cfg_tdata   = cfg_dir;
  assign axis.data_tvalid = vld_p2;
  assign axis.data_tdata  = {{INPUT_WIDTH{1'b0}}, re_p2};
  assign axis.data_tlast  = last_p2;
  assign o_busy           = (state != IDLE);
  assign o_frame_done     = frame_done;
  assign o_overrun        = overrun;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Randomized bench for fft_frame_feeder: a queue-based frame model predicts every
// streamed beat; a second small instance (N = 8) covers the inverse direction.
module tb_fft_frame_feeder;
  localparam int L  = 10;
  localparam int N  = 1 << L;
  localparam int SW = 8;
  localparam int IW = 16;
  localparam int LS = 3;
  localparam int NS = 1 << LS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, arm, cont, dir, smp_vld;
  logic [SW-1:0] smp;
  logic          busy, fdone, ovr;
  logic          arm_s, cont_s, dir_s, smp_vld_s;
  logic [SW-1:0] smp_s;
  logic          busy_s, fdone_s, ovr_s;

  fft_frame_feeder_if #(.INPUT_WIDTH(IW)) axis ();
  fft_frame_feeder_if #(.INPUT_WIDTH(IW)) axis_s ();

  fft_frame_feeder #(.LOGS_FFT_LEN(L), .SAMPLE_WIDTH(SW), .INPUT_WIDTH(IW)) dut (
    .i_aclk(clk), .i_rst(rst), .i_arm(arm), .i_continuous(cont), .i_fft_dir(dir),
    .i_smp_vld(smp_vld), .i_smp(smp), .axis(axis),
    .o_busy(busy), .o_frame_done(fdone), .o_overrun(ovr)
  );

  fft_frame_feeder #(.LOGS_FFT_LEN(LS), .SAMPLE_WIDTH(SW), .INPUT_WIDTH(IW)) dut_s (
    .i_aclk(clk), .i_rst(rst), .i_arm(arm_s), .i_continuous(cont_s), .i_fft_dir(dir_s),
    .i_smp_vld(smp_vld_s), .i_smp(smp_s), .axis(axis_s),
    .o_busy(busy_s), .o_frame_done(fdone_s), .o_overrun(ovr_s)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Offset-binary sample as a signed value, placed in the re field with im = 0.
  function automatic logic [31:0] ref_beat(input int s);
    int v;
    v = s - 128;
    return {16'h0000, 16'(v)};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic bp = 1'b0;
  always @(posedge clk) begin
    #1;
    axis.data_tready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  logic [32:0] got_q[$];
  logic [31:0] exp_q[$];
  int          hs_cyc_q[$];
  int          last_cyc_q[$];
  int          fd_cyc_q[$];
  logic        fd_busy_q[$];
  logic        cfg_q[$];
  int          fd_cnt = 0;
  logic        mon_en = 1'b1;
  logic        stall_pend = 1'b0;
  logic [32:0] stall_val;
  logic [7:0]  hist [65536];

  // Labels use the index of the rising edge at which the event is sampled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_pend) begin
        chk("stall_vld", axis.data_tvalid, 1);
        chk("stall_data", {axis.data_tlast, axis.data_tdata}, stall_val);
      end
      stall_pend = axis.data_tvalid && !axis.data_tready;
      stall_val  = {axis.data_tlast, axis.data_tdata};
      if (axis.data_tvalid && axis.data_tready) begin
        got_q.push_back({axis.data_tlast, axis.data_tdata});
        hs_cyc_q.push_back(cyc + 1);
        if (axis.data_tlast) last_cyc_q.push_back(cyc + 1);
      end
      if (axis.cfg_tvalid) cfg_q.push_back(axis.cfg_tdata);
      if (fdone) begin
        fd_cnt++;
        fd_cyc_q.push_back(cyc + 1);
        fd_busy_q.push_back(busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete(); exp_q.delete(); hs_cyc_q.delete(); last_cyc_q.delete();
    fd_cyc_q.delete(); fd_busy_q.delete(); cfg_q.delete();
    fd_cnt = 0;
  endtask

  task automatic wait_fd(input int target, input string tag);
    for (int i = 0; i < 20000 && fd_cnt < target; i++) tick();
    chk(tag, fd_cnt, target);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"}, got_q[i][31:0], exp_q[i]);
      chk({tag, "_last"}, got_q[i][32], (i % N) == N - 1);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic fill_every_cycle(input bit record);
    for (int k = 0; k < N; k++) begin
      smp_vld = 1'b1;
      smp     = SW'($urandom);
      if (record) exp_q.push_back(ref_beat(int'(smp)));
      tick();
    end
    smp_vld = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed %0d frames", fd_cnt);
    $fatal(1);
  end

  initial begin
    int cnt;
    int arm_cyc;
    int s;
    logic [32:0] sm_got[$];
    logic [31:0] sm_exp[$];
    logic        sm_cfg[$];
    int          sm_fd;

    rst = 1'b1; arm = 1'b0; cont = 1'b0; dir = 1'b1; smp_vld = 1'b0; smp = '0;
    arm_s = 1'b0; cont_s = 1'b0; dir_s = 1'b0; smp_vld_s = 1'b0; smp_s = '0;
    axis.data_tready = 1'b1;
    axis_s.data_tready = 1'b1;
    repeat (3) tick();

    chk("rst_ctl", {axis.cfg_tvalid, axis.cfg_tdata, axis.data_tvalid, axis.data_tlast,
                    busy, fdone, ovr}, 0);
    chk("rst_data", axis.data_tdata, 0);
    rst = 1'b0;
    tick();

    // Ramp frame, no back-pressure; a stray strobe in IDLE must be ignored.
    smp_vld = 1'b1; smp = 8'h55;
    tick();
    smp_vld = 1'b0;
    clear_logs();
    do_arm();
    chk("arm_busy", busy, 1);
    for (int k = 0; k < N; k++) begin
      smp_vld = 1'b1;
      smp     = SW'(k);
      exp_q.push_back(ref_beat(k & 255));
      tick();
    end
    smp_vld = 1'b0;
    wait_fd(1, "ramp_done");
    tick();
    check_stream("ramp");
    chk("ramp_cfg_n", cfg_q.size(), 1);
    if (cfg_q.size() > 0) chk("ramp_cfg_dir", cfg_q[0], 1);
    if (hs_cyc_q.size() == N) chk("ramp_burst", hs_cyc_q[N-1] - hs_cyc_q[0], N - 1);
    if (fd_cyc_q.size() > 0 && last_cyc_q.size() > 0)
      chk("ramp_fd_time", fd_cyc_q[0], last_cyc_q[0] + 1);
    if (fd_busy_q.size() > 0) chk("ramp_busy_fall", fd_busy_q[0], 0);
    chk("ramp_no_ovr", ovr, 0);

    // Random back-pressure, gapped input, and overrun strobes during SEND.
    clear_logs();
    bp = 1'b1;
    do_arm();
    cnt = 0;
    while (cnt < N) begin
      smp_vld = ($urandom_range(0, 3) != 0);
      smp     = SW'($urandom);
      if (smp_vld) begin
        exp_q.push_back(ref_beat(int'(smp)));
        cnt++;
      end
      tick();
    end
    smp_vld = 1'b0;
    for (int i = 0; i < 5000 && !(cfg_q.size() >= 1 && got_q.size() >= 10); i++) tick();
    chk("bp_in_send", got_q.size() >= 10, 1);
    for (int p = 0; p < 5; p++) begin
      smp_vld = 1'b1;
      smp     = SW'($urandom);
      tick();
      smp_vld = 1'b0;
      tick();
      tick();
    end
    chk("ovr_set", ovr, 1);
    wait_fd(1, "bp_done");
    tick();
    check_stream("bp");
    chk("bp_cfg_n", cfg_q.size(), 1);
    chk("ovr_sticky", ovr, 1);
    do_arm();
    chk("ovr_clear", ovr, 0);

    // Reset in the middle of SEND, then a clean inverse-direction frame.
    clear_logs();
    dir = 1'b0;
    fill_every_cycle(1'b0);
    for (int i = 0; i < 10000 && got_q.size() < 500; i++) tick();
    chk("beat500", got_q.size(), 500);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_mid_ctl", {axis.cfg_tvalid, axis.cfg_tdata, axis.data_tvalid, axis.data_tlast,
                        busy, fdone, ovr}, 0);
    chk("rst_mid_data", axis.data_tdata, 0);
    rst = 1'b0;
    stall_pend = 1'b0;
    clear_logs();
    mon_en = 1'b1;
    tick();
    do_arm();
    fill_every_cycle(1'b1);
    wait_fd(1, "inv_done");
    tick();
    check_stream("inv");
    chk("inv_cfg_n", cfg_q.size(), 1);
    if (cfg_q.size() > 0) chk("inv_cfg_dir", cfg_q[0], 0);

    // Continuous mode with an uninterrupted sample stream.
    clear_logs();
    dir = 1'b1;
    cont = 1'b1;
    arm_cyc = 0;
    for (int i = 0; i < 20000 && fd_cnt < 3; i++) begin
      arm     = (i == 0);
      smp_vld = 1'b1;
      smp     = SW'($urandom);
      hist[(cyc + 1) & 16'hFFFF] = smp;
      if (i == 0) arm_cyc = cyc + 1;
      tick();
    end
    arm = 1'b0;
    cont = 1'b0;
    smp_vld = 1'b0;
    chk("cont_frames", fd_cnt, 3);
    chk("cont_cfg_n", cfg_q.size(), 3);
    chk("cont_len", got_q.size(), 3 * N);
    if (got_q.size() == 3 * N && last_cyc_q.size() >= 2) begin
      for (int f = 0; f < 3; f++) begin
        s = (f == 0) ? arm_cyc + 1 : last_cyc_q[f-1] + 1;
        for (int j = 0; j < N; j++) begin
          chk("cont_data", got_q[f*N + j][31:0], ref_beat(int'(hist[(s + j) & 16'hFFFF])));
          chk("cont_last", got_q[f*N + j][32], j == N - 1);
        end
      end
    end
    if (fd_busy_q.size() == 3) chk("cont_busy", fd_busy_q[2], 1);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall_pend = 1'b0;
    tick();

    // Small instance: N = 8, inverse direction.
    arm_s = 1'b1;
    tick();
    arm_s = 1'b0;
    for (int k = 0; k < NS; k++) begin
      smp_vld_s = 1'b1;
      smp_s     = SW'($urandom);
      sm_exp.push_back(ref_beat(int'(smp_s)));
      tick();
    end
    smp_vld_s = 1'b0;
    sm_fd = 0;
    for (int i = 0; i < 40; i++) begin
      if (axis_s.cfg_tvalid) sm_cfg.push_back(axis_s.cfg_tdata);
      if (axis_s.data_tvalid) sm_got.push_back({axis_s.data_tlast, axis_s.data_tdata});
      if (fdone_s) sm_fd++;
      tick();
    end
    chk("small_len", sm_got.size(), NS);
    chk("small_cfg_n", sm_cfg.size(), 1);
    if (sm_cfg.size() > 0) chk("small_cfg_dir", sm_cfg[0], 0);
    chk("small_done", sm_fd, 1);
    for (int i = 0; i < sm_got.size() && i < NS; i++) begin
      chk("small_data", sm_got[i][31:0], sm_exp[i]);
      chk("small_last", sm_got[i][32], i == NS - 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
